// File: rtl/pipeline_trace_pkg.sv
// Shared widths and token types for the pipeline retire tracker.
// One token is the shadow copy of an instruction as it moves through a pipeline stage.
package pipeline_trace_pkg;

  localparam int SEQ_W   = 8;
  localparam int CYC_W   = 32;
  localparam int STALL_W = 4;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IF  = 3'd0,
    ID  = 3'd1,
    EX  = 3'd2,
    MEM = 3'd3,
    WB  = 3'd4
  } stage_t;

  typedef struct packed {
    logic               valid;
    logic [SEQ_W-1:0]   seq;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CYC_W-1:0]   fetch_cyc;
    logic [STALL_W-1:0] stall_cnt;
  } token_t;

  // An empty slot carries an all-zero payload, so retire fields read 0 when nothing retires.
  localparam token_t BUBBLE = '0;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_retire_tracker_if.sv
// Fetch/hazard inputs and retire-event outputs of the retire tracker.
// The perf counter signals exist only when RETIRE_PERF_CNT_EN is defined.
interface pipeline_retire_tracker_if;
  import pipeline_trace_pkg::*;

  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               stall;
  logic               flush;

  logic               retire_valid;
  logic [SEQ_W-1:0]   retire_seq;
  logic [PC_W-1:0]    retire_pc;
  logic [INSTR_W-1:0] retire_instr;
  logic [CYC_W-1:0]   retire_fetch_cyc;
  logic [STALL_W-1:0] retire_stall_cnt;
  logic [CYC_W-1:0]   cycle;
`ifdef RETIRE_PERF_CNT_EN
  logic [CYC_W-1:0]   perf_retired;
  logic [CYC_W-1:0]   perf_bubbles;
`endif

  modport master (
    output if_valid, if_pc, if_instr, stall, flush,
    input  retire_valid, retire_seq, retire_pc, retire_instr,
           retire_fetch_cyc, retire_stall_cnt, cycle
`ifdef RETIRE_PERF_CNT_EN
           , perf_retired, perf_bubbles
`endif
  );

  modport slave (
    input  if_valid, if_pc, if_instr, stall, flush,
    output retire_valid, retire_seq, retire_pc, retire_instr,
           retire_fetch_cyc, retire_stall_cnt, cycle
`ifdef RETIRE_PERF_CNT_EN
           , perf_retired, perf_bubbles
`endif
  );

endinterface

// File: rtl/trace_slot_reg.sv
// One shadow stage register holding a token. Kill and bubble both empty the slot;
// hold keeps the token and counts a stalled cycle against it.
module trace_slot_reg
  import pipeline_trace_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   hold,
  input  logic   bubble,
  input  logic   kill,
  input  token_t d,
  output token_t q
);

  always_ff @(posedge clk) begin
    if (rst || kill || bubble) begin
      q <= BUBBLE;
    end else if (hold) begin
      if (q.valid) begin
        q.stall_cnt <= sat_inc(q.stall_cnt);
      end
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_retire_tracker.sv
// Shadows the 5-stage pipeline with sequence-tagged tokens and emits one retire event per WB exit.
// Define RETIRE_PERF_CNT_EN to add the perf_retired / perf_bubbles counters.
module pipeline_retire_tracker
  import pipeline_trace_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  pipeline_retire_tracker_if.slave   bus
);

  token_t           if_d;
  token_t           if_q;
  token_t           id_q;
  token_t           ex_q;
  token_t           mem_q;
  token_t           wb_q;
  logic [CYC_W-1:0] cycle_q;
  logic [CYC_W-1:0] cycle_next;
  logic [SEQ_W-1:0] next_seq;
  logic             fetch_accept;

  // A fetch coinciding with a stall or flush is dropped; upstream re-presents it.
  assign fetch_accept = bus.if_valid && !bus.stall && !bus.flush;
  assign cycle_next   = cycle_q + CYC_W'(1);

  // The stamp is the cycle number the token spends in IF, i.e. the count after this edge.
  always_comb begin
    if_d = BUBBLE;
    if (fetch_accept) begin
      if_d.valid     = 1'b1;
      if_d.seq       = next_seq;
      if_d.pc        = bus.if_pc;
      if_d.instr     = bus.if_instr;
      if_d.fetch_cyc = cycle_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q  <= '0;
      next_seq <= '0;
    end else begin
      cycle_q <= cycle_next;
      if (fetch_accept) begin
        next_seq <= next_seq + SEQ_W'(1);
      end
    end
  end

  trace_slot_reg u_if (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (bus.stall),
    .bubble (1'b0),
    .kill   (bus.flush),
    .d      (if_d),
    .q      (if_q)
  );

  trace_slot_reg u_id (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (bus.stall),
    .bubble (1'b0),
    .kill   (bus.flush),
    .d      (if_q),
    .q      (id_q)
  );

  // EX takes a bubble on stall (ID is held) and on flush (the ID token is killed).
  trace_slot_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (1'b0),
    .bubble (bus.stall || bus.flush),
    .kill   (1'b0),
    .d      (id_q),
    .q      (ex_q)
  );

  trace_slot_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (1'b0),
    .bubble (1'b0),
    .kill   (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  trace_slot_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .load   (1'b1),
    .hold   (1'b0),
    .bubble (1'b0),
    .kill   (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign bus.retire_valid     = wb_q.valid;
  assign bus.retire_seq       = wb_q.valid ? wb_q.seq       : '0;
  assign bus.retire_pc        = wb_q.valid ? wb_q.pc        : '0;
  assign bus.retire_instr     = wb_q.valid ? wb_q.instr     : '0;
  assign bus.retire_fetch_cyc = wb_q.valid ? wb_q.fetch_cyc : '0;
  assign bus.retire_stall_cnt = wb_q.valid ? wb_q.stall_cnt : '0;
  assign bus.cycle            = cycle_q;

`ifdef RETIRE_PERF_CNT_EN
  logic [CYC_W-1:0] perf_retired_q;
  logic [CYC_W-1:0] perf_bubbles_q;
  logic             seen_retire;

  // WB always loads MEM, so mem_q.valid is next cycle's retire_valid; counts include the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_bubbles_q <= '0;
      seen_retire    <= 1'b0;
    end else begin
      if (mem_q.valid) begin
        perf_retired_q <= perf_retired_q + CYC_W'(1);
      end else if (seen_retire || wb_q.valid) begin
        perf_bubbles_q <= perf_bubbles_q + CYC_W'(1);
      end
      seen_retire <= seen_retire || wb_q.valid;
    end
  end

  assign bus.perf_retired = perf_retired_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_pipeline_retire_tracker.sv
// Self-checking bench for pipeline_retire_tracker: directed scenarios plus random traffic,
// compared each cycle against a per-instruction stage model.
module tb_pipeline_retire_tracker;

  localparam int unsigned SEQ_MOD   = 256;
  localparam int unsigned STALL_MAX = 15;

  typedef struct {
    int          stage;
    int unsigned seq;
    int unsigned pc;
    int unsigned instr;
    int unsigned fetch_cyc;
    int unsigned stall_cnt;
  } mtok_t;

  logic clk = 1'b0;
  logic rst;

  pipeline_retire_tracker_if bus();

  pipeline_retire_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  mtok_t       pipe[$];
  int unsigned m_cycle;
  int unsigned m_next_seq;
  int unsigned m_retired;
  int unsigned m_bubbles;
  bit          m_seen;
  int unsigned retired_log[$];
  int          check_count;
  int          error_count;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Each instruction advances one stage per edge unless a stall pins it in IF/ID or a flush kills it there.
  task automatic modelEdge();
    mtok_t t;
    mtok_t nxt[$];
    if (rst) begin
      pipe.delete();
      m_cycle    = 0;
      m_next_seq = 0;
      m_retired  = 0;
      m_bubbles  = 0;
      m_seen     = 0;
    end else begin
      m_cycle++;
      foreach (pipe[i]) begin
        t = pipe[i];
        if (t.stage <= 1 && bus.flush) continue;
        if (t.stage <= 1 && bus.stall) begin
          if (t.stall_cnt < STALL_MAX) t.stall_cnt++;
          nxt.push_back(t);
        end else begin
          t.stage++;
          if (t.stage < 5) nxt.push_back(t);
        end
      end
      if (bus.if_valid && !bus.stall && !bus.flush) begin
        t.stage     = 0;
        t.seq       = m_next_seq % SEQ_MOD;
        t.pc        = bus.if_pc;
        t.instr     = bus.if_instr;
        t.fetch_cyc = m_cycle;
        t.stall_cnt = 0;
        nxt.push_back(t);
        m_next_seq++;
      end
      pipe = nxt;
      t.stage = -1;
      foreach (pipe[i]) if (pipe[i].stage == 4) t.stage = 4;
      if (t.stage == 4) begin
        m_retired++;
        m_seen = 1;
      end else if (m_seen) begin
        m_bubbles++;
      end
    end
  endtask

  task automatic checkAll();
    int w;
    w = -1;
    foreach (pipe[i]) if (pipe[i].stage == 4) w = i;
    if (w >= 0) begin
      checkOutput("retire_valid", bus.retire_valid, 1);
      checkOutput("retire_seq", bus.retire_seq, pipe[w].seq);
      checkOutput("retire_pc", bus.retire_pc, pipe[w].pc);
      checkOutput("retire_instr", bus.retire_instr, pipe[w].instr);
      checkOutput("retire_fetch_cyc", bus.retire_fetch_cyc, pipe[w].fetch_cyc);
      checkOutput("retire_stall_cnt", bus.retire_stall_cnt, pipe[w].stall_cnt);
    end else begin
      checkOutput("retire_valid", bus.retire_valid, 0);
      checkOutput("retire_seq_idle", bus.retire_seq, 0);
      checkOutput("retire_pc_idle", bus.retire_pc, 0);
      checkOutput("retire_fetch_cyc_idle", bus.retire_fetch_cyc, 0);
      checkOutput("retire_stall_cnt_idle", bus.retire_stall_cnt, 0);
    end
    checkOutput("cycle", bus.cycle, m_cycle);
`ifdef RETIRE_PERF_CNT_EN
    checkOutput("perf_retired", bus.perf_retired, m_retired);
    checkOutput("perf_bubbles", bus.perf_bubbles, m_bubbles);
`endif
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [15:0] pc,
                               input logic [15:0] instr, input bit s, input bit f);
    rst          = r;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    bus.stall    = s;
    bus.flush    = f;
    @(posedge clk);
    #1;
    modelEdge();
    checkAll();
    if (bus.retire_valid) retired_log.push_back(bus.retire_seq);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic waitRetire(input int budget, output int waited);
    waited = 0;
    while (!bus.retire_valid && waited < budget) begin
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
      waited++;
    end
    if (!bus.retire_valid) checkOutput("retire_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          waited;
    int unsigned base;
    check_count = 0;
    error_count = 0;

    applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
    applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
    checkOutput("rst_valid", bus.retire_valid, 0);
    checkOutput("rst_cycle", bus.cycle, 0);

    // Three back-to-back fetches retire after edges 5, 6, 7
    applyStimulus(0, 1, 16'h0000, 16'hA000, 0, 0);
    applyStimulus(0, 1, 16'h0002, 16'hA001, 0, 0);
    applyStimulus(0, 1, 16'h0004, 16'hA002, 0, 0);
    idle(1);
    checkOutput("lat_edge4_valid", bus.retire_valid, 0);
    idle(1);
    checkOutput("lat_edge5_valid", bus.retire_valid, 1);
    checkOutput("lat_edge5_seq", bus.retire_seq, 0);
    checkOutput("lat_edge5_fcyc", bus.retire_fetch_cyc, 1);
    checkOutput("lat_edge5_stall", bus.retire_stall_cnt, 0);
    idle(1);
    checkOutput("lat_edge6_seq", bus.retire_seq, 1);
    checkOutput("lat_edge6_fcyc", bus.retire_fetch_cyc, 2);
    idle(1);
    checkOutput("lat_edge7_seq", bus.retire_seq, 2);
    checkOutput("lat_edge7_pc", bus.retire_pc, 16'h0004);
    checkOutput("lat_edge7_fcyc", bus.retire_fetch_cyc, 3);
    idle(1);
    checkOutput("lat_edge8_valid", bus.retire_valid, 0);
    idle(2);

    // Two stall cycles while the token sits in ID
    applyStimulus(0, 1, 16'h0010, 16'hB000, 0, 0);
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
    lat = 3;
    waitRetire(30, waited);
    lat += waited;
    checkOutput("stall_latency", lat, 6);
    checkOutput("stall_cnt_2", bus.retire_stall_cnt, 2);
    checkOutput("stall_pc", bus.retire_pc, 16'h0010);
    idle(3);

    // Flush with A in EX: A retires, B and the IF token are killed
    retired_log.delete();
    base = m_next_seq;
    applyStimulus(0, 1, 16'h0020, 16'hC000, 0, 0);
    applyStimulus(0, 1, 16'h0022, 16'hC001, 0, 0);
    applyStimulus(0, 1, 16'h0024, 16'hC002, 0, 0);
    applyStimulus(0, 1, 16'h0026, 16'hC003, 0, 1);
    applyStimulus(0, 1, 16'h0040, 16'hC004, 0, 0);
    idle(8);
    checkOutput("flush_retire_count", retired_log.size(), 2);
    if (retired_log.size() == 2) begin
      checkOutput("flush_a_seq", retired_log[0], base % SEQ_MOD);
      checkOutput("flush_next_seq", retired_log[1], (base + 3) % SEQ_MOD);
    end

    // Long stall saturates the stall counter
    applyStimulus(0, 1, 16'h0050, 16'hD000, 0, 0);
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 16'h0, 16'h0, 1, 0);
    waitRetire(30, waited);
    checkOutput("stall_saturated", bus.retire_stall_cnt, STALL_MAX);
    idle(3);

    // 300 back-to-back fetches: sequence IDs wrap without a gap
    retired_log.delete();
    base = m_next_seq;
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 16'($urandom), 16'($urandom), 0, 0);
    idle(6);
    checkOutput("wrap_retire_count", retired_log.size(), 300);
    foreach (retired_log[k]) checkOutput("wrap_seq", retired_log[k], (base + k) % SEQ_MOD);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, $urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 9) < 2, $urandom_range(0, 14) == 0);
    end
    idle(6);

    // Reset with four tokens in flight
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'(16'h0100 + 2 * i), 16'hE000, 0, 0);
    applyStimulus(1, 0, 16'h0, 16'h0, 0, 0);
    checkOutput("midrst_cycle", bus.cycle, 0);
    checkOutput("midrst_valid", bus.retire_valid, 0);
`ifdef RETIRE_PERF_CNT_EN
    checkOutput("midrst_perf_retired", bus.perf_retired, 0);
`endif
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      checkOutput("postrst_quiet", bus.retire_valid, 0);
      checkOutput("postrst_cycle", bus.cycle, i);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/pipeline_retire_tracker.md
Name: pipeline_retire_tracker

Overview:
- Synthesizable companion to the CPU's 5-stage pipeline (IF, ID, EX, MEM, WB).
- Tags every fetched instruction with a sequence ID and fetch-cycle stamp, and carries that token through shadow stage registers under the same stall and flush rules as the datapath.
- Emits one registered retire event per instruction leaving WB.
- The testbench pipeline display consumes these events, so its per-instruction reports are driven from RTL-accurate tokens rather than re-derived stage guesses.

Parameters:
- SEQ_W, 8: sequence ID width; wraps modulo 2^SEQ_W.
- CYC_W, 32: free-running cycle counter width; wraps.
- STALL_W, 4: per-instruction stall counter width; saturates at all-ones.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch produced an instruction this cycle.
- if_pc  in  16  PC of fetched instruction.
- if_instr  in  16  fetched instruction word.
- stall  in  1  hazard stall: IF and ID hold, bubble enters EX.
- flush  in  1  taken-branch flush: IF and ID tokens killed.
- retire_valid  out  1  WB token valid this cycle.
- retire_seq  out  SEQ_W  sequence ID of the retiring instruction.
- retire_pc  out  16  PC of the retiring instruction.
- retire_instr  out  16  instruction word of the retiring instruction.
- retire_fetch_cyc  out  CYC_W  cycle stamp when the instruction entered IF.
- retire_stall_cnt  out  STALL_W  cycles the instruction spent stalled in IF or ID.
- cycle  out  CYC_W  current cycle count.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All five slot valid bits cleared; every payload field zeroed.
  - cycle=0, next_seq=0.
  - All outputs 0 on the following cycle.
  - Reset mid-operation discards in-flight tokens; no retire event for them.
- Cycle counter: cycle increments by 1 every non-reset edge; wraps at 2^CYC_W.
- Token fields: valid, seq, pc, instr, fetch_cyc, stall_cnt.
- Normal edge (stall=0, flush=0):
  - WB<=MEM, MEM<=EX, EX<=ID, ID<=IF.
  - IF<={if_valid, next_seq, if_pc, if_instr, cycle, 0}.
  - next_seq increments only when if_valid=1.
- Stall edge (stall=1, flush=0):
  - IF and ID hold.
  - stall_cnt of each valid IF/ID token increments, saturating.
  - EX<=bubble (valid=0); MEM<=EX and WB<=MEM still advance.
  - if_valid is ignored; next_seq does not advance.
- Flush edge (flush=1, stall either value):
  - Flush dominates.
  - IF and ID are cleared to invalid.
  - EX<=bubble, so the ID token is killed, not advanced.
  - MEM and WB advance normally.
  - next_seq does not advance; killed IDs are not reused and are reissued starting from next_seq.
- Retire outputs:
  - Driven directly from the WB slot (registered, no combinational path from inputs).
  - retire_valid=WB.valid; other retire fields are 0 when invalid.
- Latency: if_valid=1 sampled at edge k with no stall or flush gives retire_valid=1 after edge k+4.
  - Each stall edge adds 1 cycle.
- Ordering: retire_seq is strictly increasing mod 2^SEQ_W; gaps are allowed only across flushes.
- Simultaneous if_valid with stall or flush: the fetch is dropped. Upstream re-presents it; that is the datapath's responsibility.

Optional Feature:
- Macro: RETIRE_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_retired (CYC_W): count of retire_valid cycles.
  - perf_bubbles (CYC_W): count of cycles where WB.valid=0 after the first retire.
- Both counters clear on reset and wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipeline_trace_pkg holds:
  - stage_t enum {IF, ID, EX, MEM, WB}.
  - token_t packed struct {valid, seq, pc, instr, fetch_cyc, stall_cnt}.
  - Width localparams and a BUBBLE constant.
- Sub-module trace_slot_reg: one token register with load, hold, bubble and kill controls plus saturating stall_cnt increment.
  - Instantiated 5 times.
  - IF and ID slots use hold; EX, MEM and WB slots always load.

Test Plan:
- Reset, then 3 consecutive fetches at PC 0x0000, 0x0002, 0x0004:
  - retire_valid high after edges 5, 6, 7.
  - seq 0, 1, 2; fetch_cyc 1, 2, 3; stall_cnt 0.
- Fetch at PC 0x0010, then stall for 2 cycles while it sits in ID:
  - retires 2 cycles later than unstalled, with stall_cnt=2.
  - exactly one bubble (retire_valid=0) cycle precedes it per stall cycle.
- Fetch A then B, flush when A is in EX:
  - A retires.
  - B (in ID) and the IF token never retire.
  - next fetch retires with seq = B.seq+2.
- Stall held for 20 cycles with STALL_W=4: retiring token shows stall_cnt=15 (saturated).
- 300 back-to-back fetches with SEQ_W=8: retire_seq wraps 255 -> 0 with no gap.
- Assert rst with 4 tokens in flight: no retire_valid for 5 cycles after reset release without if_valid; cycle restarts at 0.
  - With RETIRE_PERF_CNT_EN, perf_retired=0 after reset.
